// File: rtl/hcsr04_echo_responder.sv
// Cycle-accurate stand-in for an HC-SR04 sensor: accepts a trigger pulse and answers with an
// echo pulse whose width encodes Distance_Set after the burst delay.
module hcsr04_echo_responder #(
  parameter int unsigned TICKS_PER_US = 50,
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned MAX_CM       = 200,
  parameter int unsigned TIMEOUT_US   = 38000,
  parameter int unsigned HOLDOFF_US   = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Trigger,
  input  logic [7:0] Distance_Set,
  output logic       Echo,
  output logic       Busy,
  output logic       Short_Trig
);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_PER_US - 1);
  localparam logic [15:0]   MIN_W    = 16'(MIN_TRIG_US);
  localparam logic [15:0]   BURST_W  = 16'(BURST_US);
  localparam logic [15:0]   TMO_W    = 16'(TIMEOUT_US);
  localparam logic [15:0]   HOLD_W   = 16'(HOLDOFF_US);
  localparam logic [8:0]    MAX_D    = 9'(MAX_CM);

  state_t         state_q;
  logic           s1_q, s2_q, s3_q;
  logic [1:0]     vld_q;
  logic           arm_q;
  logic [PW-1:0]  pre_q;
  logic [15:0]    us_q;
  logic [7:0]     dist_q;
  logic           echo_q, busy_q, short_q;

  logic           rise, fall, tick_end, width_ok;
  logic [15:0]    echo_w;
  logic [31:0]    prod;

  // arm_q blocks a level that is already high when reset releases from looking like an edge
  assign rise     = s2_q & ~s3_q & arm_q;
  assign fall     = ~s2_q & s3_q;
  assign tick_end = (pre_q == PRE_MAX);

  // The rise-detect cycle is part of the pulse but precedes TRIG_HI, so one cycle less is required here
  assign width_ok = (us_q >= MIN_W) || ((us_q == MIN_W - 16'd1) && tick_end);

  assign prod   = 32'(dist_q) * 32'(US_PER_CM);
  assign echo_w = (dist_q == 8'd0 || {1'b0, dist_q} > MAX_D) ? TMO_W : prod[15:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 2'b00;
      arm_q   <= 1'b0;
      pre_q   <= '0;
      us_q    <= '0;
      dist_q  <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      s1_q    <= Trigger;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= {vld_q[0], 1'b1};
      short_q <= 1'b0;
      if (vld_q[1] && !s2_q) arm_q <= 1'b1;

      if (state_q != IDLE) begin
        if (tick_end) begin
          pre_q <= '0;
          if (!(state_q == TRIG_HI && us_q >= MIN_W)) us_q <= us_q + 16'd1;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= TRIG_HI;
            busy_q  <= 1'b1;
            pre_q   <= '0;
            us_q    <= '0;
          end
        end
        TRIG_HI: begin
          if (fall) begin
            pre_q <= '0;
            us_q  <= '0;
            if (width_ok) begin
              state_q <= BURST;
              dist_q  <= Distance_Set;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              short_q <= 1'b1;
            end
          end
        end
        BURST: begin
          if (tick_end && us_q == BURST_W - 16'd1) begin
            state_q <= ECHO;
            echo_q  <= 1'b1;
            pre_q   <= '0;
            us_q    <= '0;
          end
        end
        ECHO: begin
          if (tick_end && us_q == echo_w - 16'd1) begin
            state_q <= HOLDOFF;
            echo_q  <= 1'b0;
            pre_q   <= '0;
            us_q    <= '0;
          end
        end
        HOLDOFF: begin
          if (tick_end && us_q == HOLD_W - 16'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            us_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Echo       = echo_q;
  assign Busy       = busy_q;
  assign Short_Trig = short_q;

endmodule
